rgb_fade_sequencer: RTL
=======================

// Module: rgb_fade_sequencer
// PURPOSE
// Sequences the RGB PWM datapath: generates the shared period-start strobe and per-channel
// duty words that ramp up/hold/ramp down in a repeating "breathing" cycle. Sits between
// the top-level control and the three PWM comparators; duty words change only at PWM
// period boundaries, so the comparators never see a mid-period update (glitch-free output).
// PARAMETERS
// CNT_W         13  PWM counter/duty width; period = 2^CNT_W clk; MAX = 2^CNT_W-1
// STEP_PERIODS  64  PWM periods per ramp/hold tick (>=1)
// HOLD_PERIODS  32  ticks spent in each hold state (>=1)
// PORTS
// clk           in   1      system clock (50 MHz)
// rst_n         in   1      asynchronous active-low reset
// enable        in   1      1 = run sequence; 0 = return to IDLE, duties 0
// step_r        in   8      red duty increment/decrement per tick (0 = channel frozen)
// step_g        in   8      green step
// step_b        in   8      blue step
// period_start  out  1      one-clk pulse at start of each PWM period (drives PWM counter clear)
// duty_r        out  CNT_W  red duty word
// duty_g        out  CNT_W  green duty word
// duty_b        out  CNT_W  blue duty word
// phase         out  3      current state encoding
// cycle_done    out  1      one-clk pulse when a full up/down cycle completes
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, period counter pcnt=0, tick/hold counters 0.
// - States: IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4; all registered.
// - IDLE -> RAMP_UP on first clk with enable=1; pcnt starts at 0, duties 0.
// - pcnt (CNT_W bits) increments every clk outside IDLE, wraps MAX->0.
// - period_start = 1 for the clk in which pcnt==0 and state!=IDLE; first pulse one clk after leaving IDLE.
// - Boundary = edge where pcnt wraps MAX->0. Tick counter counts boundaries 0..STEP_PERIODS-1;
//   tick = boundary with tick counter at STEP_PERIODS-1. All duty/state changes occur only on ticks.
// - RAMP_UP tick: duty_x <= min(duty_x+step_x, MAX), zero-extended add in CNT_W+1 bits.
//   Channel done if new duty==MAX or step_x==0. All three done -> HOLD_HIGH on same edge.
// - RAMP_DOWN tick: duty_x <= max(duty_x-step_x, 0); done if new duty==0 or step_x==0.
//   All done -> HOLD_LOW on same edge; cycle_done pulses 1 clk coincident with the transition.
// - HOLD_x: hold counter cleared on entry, +1 per tick; after HOLD_PERIODS ticks
//   HOLD_HIGH -> RAMP_DOWN, HOLD_LOW -> RAMP_UP. Duties unchanged in hold.
// - step_x sampled live at each tick; change mid-ramp takes effect next tick.
// - All steps 0: each ramp completes on its first tick, duties unchanged.
// - enable=0 in any state: next edge -> IDLE, duties/pcnt/counters 0, no cycle_done.
// - Async rst_n low mid-operation: immediate return to reset values.
// CONFIGURATION
// - FADE_HOLD_EN defined: hold states present as above.
// - FADE_HOLD_EN undefined: no hold states/counter; RAMP_UP done -> RAMP_DOWN,
//   RAMP_DOWN done -> RAMP_UP (cycle_done still pulses); phase never shows 2 or 4.
// TESTING (CNT_W=4, STEP_PERIODS=2, HOLD_PERIODS=3; tick every 32 clk)
// - Reset/idle: rst_n=0 then enable=0 -> all outputs 0, period_start never pulses.
// - Ramp up: enable=1, steps r=4,g=8,b=16 -> per tick r 4,8,12,15; g 8,15,15; b 15;
//   phase=2 after 4th tick; duty changes coincide with period_start.
// - Hold/down (FADE_HOLD_EN): 3 ticks later phase=3; r 11,7,3,0; g 7,0; b 0; cycle_done 1 clk, phase=4.
// - Disable mid-ramp: enable=0 at r=8 -> next clk phase=0, duties 0; re-enable restarts from 0.
// - Zero step: step_g=0 -> duty_g stays 0 throughout, sequence still advances on r/b.
// - Macro off: same as ramp-up test -> phase 1->3 directly after 4th tick, no hold ticks.

Source files
------------

// File: rtl/rgb_fade_sequencer_if.sv
// Control/datapath bundle between the top-level control and the RGB fade sequencer.
// The bus has no handshake: enable is a level and step_* are sampled live at each tick.
interface rgb_fade_sequencer_if #(
  parameter int CNT_W = 13
);
  logic             enable;
  logic [7:0]       step_r;
  logic [7:0]       step_g;
  logic [7:0]       step_b;
  logic             period_start;
  logic [CNT_W-1:0] duty_r;
  logic [CNT_W-1:0] duty_g;
  logic [CNT_W-1:0] duty_b;
  logic [2:0]       phase;
  logic             cycle_done;

  modport master (
    output enable, step_r, step_g, step_b,
    input  period_start, duty_r, duty_g, duty_b, phase, cycle_done
  );

  modport slave (
    input  enable, step_r, step_g, step_b,
    output period_start, duty_r, duty_g, duty_b, phase, cycle_done
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// RGB breathing sequencer: PWM period strobe plus ramp/hold duty words updated only on ticks.
// Define FADE_HOLD_EN to include the HOLD_HIGH/HOLD_LOW states and their hold counter.
module rgb_fade_sequencer #(
  parameter int CNT_W        = 13,
  parameter int STEP_PERIODS = 64,
  parameter int HOLD_PERIODS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rgb_fade_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  localparam int TICK_W = $clog2(STEP_PERIODS + 1);
  // Adder wide enough for both the duty word and an 8-bit step, plus carry.
  localparam int SUM_W  = ((CNT_W > 8) ? CNT_W : 8) + 1;
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] d, input logic [7:0] s);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(d) + SUM_W'(s);
    if (sum > SUM_W'(MAX)) return MAX;
    return sum[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] d, input logic [7:0] s);
    if (SUM_W'(s) >= SUM_W'(d)) return '0;
    return d - CNT_W'(s);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [CNT_W-1:0]   duty_r_q, duty_r_d;
  logic [CNT_W-1:0]   duty_g_q, duty_g_d;
  logic [CNT_W-1:0]   duty_b_q, duty_b_d;
  logic               period_start_q, period_start_d;
  logic               cycle_done_q, cycle_done_d;

`ifdef FADE_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
  logic [HOLD_W-1:0]  hold_q, hold_d;
`else
  logic [31:0]        hold_unused;
  assign hold_unused = 32'(HOLD_PERIODS);
`endif

  logic               boundary, tick;
  logic [CNT_W-1:0]   up_r, up_g, up_b, dn_r, dn_g, dn_b;
  logic               up_done, dn_done;

  always_comb begin
    boundary = (pcnt_q == MAX);
    tick     = boundary && (tick_q == TICK_W'(STEP_PERIODS - 1));

    up_r = sat_add(duty_r_q, bus.step_r);
    up_g = sat_add(duty_g_q, bus.step_g);
    up_b = sat_add(duty_b_q, bus.step_b);
    dn_r = sat_sub(duty_r_q, bus.step_r);
    dn_g = sat_sub(duty_g_q, bus.step_g);
    dn_b = sat_sub(duty_b_q, bus.step_b);

    // A zero step freezes its channel and never blocks the phase from advancing.
    up_done = ((up_r == MAX) || (bus.step_r == 8'd0)) &&
              ((up_g == MAX) || (bus.step_g == 8'd0)) &&
              ((up_b == MAX) || (bus.step_b == 8'd0));
    dn_done = ((dn_r == '0) || (bus.step_r == 8'd0)) &&
              ((dn_g == '0) || (bus.step_g == 8'd0)) &&
              ((dn_b == '0) || (bus.step_b == 8'd0));

    state_d      = state_q;
    pcnt_d       = pcnt_q;
    tick_d       = tick_q;
    duty_r_d     = duty_r_q;
    duty_g_d     = duty_g_q;
    duty_b_d     = duty_b_q;
    cycle_done_d = 1'b0;
`ifdef FADE_HOLD_EN
    hold_d       = hold_q;
`endif

    if (!bus.enable) begin
      state_d  = IDLE;
      pcnt_d   = '0;
      tick_d   = '0;
      duty_r_d = '0;
      duty_g_d = '0;
      duty_b_d = '0;
`ifdef FADE_HOLD_EN
      hold_d   = '0;
`endif
    end else if (state_q == IDLE) begin
      state_d = RAMP_UP;
    end else begin
      pcnt_d = pcnt_q + CNT_W'(1);
      if (boundary) tick_d = tick ? '0 : tick_q + TICK_W'(1);
      if (tick) begin
        case (state_q)
          RAMP_UP: begin
            duty_r_d = up_r;
            duty_g_d = up_g;
            duty_b_d = up_b;
            if (up_done) begin
`ifdef FADE_HOLD_EN
              state_d = HOLD_HIGH;
              hold_d  = '0;
`else
              state_d = RAMP_DOWN;
`endif
            end
          end
          RAMP_DOWN: begin
            duty_r_d = dn_r;
            duty_g_d = dn_g;
            duty_b_d = dn_b;
            if (dn_done) begin
              cycle_done_d = 1'b1;
`ifdef FADE_HOLD_EN
              state_d = HOLD_LOW;
              hold_d  = '0;
`else
              state_d = RAMP_UP;
`endif
            end
          end
`ifdef FADE_HOLD_EN
          HOLD_HIGH, HOLD_LOW: begin
            if (hold_q == HOLD_W'(HOLD_PERIODS - 1)) begin
              state_d = (state_q == HOLD_HIGH) ? RAMP_DOWN : RAMP_UP;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end

    // Strobe is registered from next-state values so it lines up with pcnt==0.
    period_start_d = (state_d != IDLE) && (pcnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pcnt_q         <= '0;
      tick_q         <= '0;
      duty_r_q       <= '0;
      duty_g_q       <= '0;
      duty_b_q       <= '0;
      period_start_q <= 1'b0;
      cycle_done_q   <= 1'b0;
`ifdef FADE_HOLD_EN
      hold_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      tick_q         <= tick_d;
      duty_r_q       <= duty_r_d;
      duty_g_q       <= duty_g_d;
      duty_b_q       <= duty_b_d;
      period_start_q <= period_start_d;
      cycle_done_q   <= cycle_done_d;
`ifdef FADE_HOLD_EN
      hold_q         <= hold_d;
`endif
    end
  end

  assign bus.period_start = period_start_q;
  assign bus.duty_r       = duty_r_q;
  assign bus.duty_g       = duty_g_q;
  assign bus.duty_b       = duty_b_q;
  assign bus.phase        = state_q;
  assign bus.cycle_done   = cycle_done_q;

endmodule
